// File: rtl/sccb_master.sv
// sccb_master: SCCB (OV7670) single-register write/read master.
// Define SCCB_ACK_CHECK_EN to abort a transaction on a missing ACK.
module sccb_master #(
    parameter int unsigned DIV    = 500,
    parameter logic [7:0]  DEV_ID = 8'h42
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic       rd_en,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic       rdy,
    output logic [7:0] rdata,
    output logic       rdata_vld,
    output logic       ack_err,
    output logic       sio_c,
    output logic       sio_d_out,
    output logic       sio_d_oe,
    input  logic       sio_d_in
);

    localparam int unsigned CW = $clog2(DIV);
    localparam logic [CW-1:0] C_Q    = CW'(DIV / 4);
    localparam logic [CW-1:0] C_H    = CW'(DIV / 2);
    localparam logic [CW-1:0] C_Q3   = CW'(3 * DIV / 4);
    localparam logic [CW-1:0] C_LAST = CW'(DIV - 1);

    typedef enum logic [2:0] {
        IDLE, START, SEND, RECV, STOP, GAP
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_q, bit_d;
    logic [3:0]    phase_q, phase_d;
    logic          rd_q, rd_d;
    logic          abort_q, abort_d;
    logic [7:0]    addr_q, addr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          vld_q, vld_d;
    logic          rdy_q, rdy_d;
    logic          sio_c_q, sio_c_d;
    logic          sda_q, sda_d;
    logic          oe_q, oe_d;
    logic          nak;
    logic          last;
    logic          adv;
    state_e        nxt;
    logic [7:0]    tx;
    logic [7:0]    txb;

    // Step sequence: phase index -> bus state for write and read.
    function automatic state_e step_state(input logic [3:0] p,
                                          input logic rd);
        state_e s;
        s = IDLE;
        if (rd) begin
            case (p)
                4'd0:       s = START;
                4'd1, 4'd2: s = SEND;
                4'd3:       s = STOP;
                4'd4:       s = GAP;
                4'd5:       s = START;
                4'd6:       s = SEND;
                4'd7:       s = RECV;
                4'd8:       s = STOP;
                default:    s = IDLE;
            endcase
        end else begin
            case (p)
                4'd0:             s = START;
                4'd1, 4'd2, 4'd3: s = SEND;
                4'd4:             s = STOP;
                default:          s = IDLE;
            endcase
        end
        return s;
    endfunction

`ifdef SCCB_ACK_CHECK_EN
    assign nak = (state_q == SEND) && (bit_q == 4'd8) &&
                 (cnt_q == C_Q3) && sio_d_in;

    logic ack_q;

    // Registered one-cycle missing-ACK strobe.
    always_ff @(posedge clk) begin
        if (rst) ack_q <= 1'b0;
        else     ack_q <= nak;
    end

    assign ack_err = ack_q;
`else
    assign nak     = 1'b0;
    assign ack_err = 1'b0;
`endif

    // Sequencer: request accept, bit/phase stepping, read capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        phase_d = phase_q;
        rd_d    = rd_q;
        abort_d = abort_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        shift_d = shift_q;
        rdata_d = rdata_q;
        vld_d   = 1'b0;
        rdy_d   = rdy_q;
        adv     = 1'b0;
        nxt     = IDLE;
        last    = (cnt_q == C_LAST);
        if (state_q != IDLE) begin
            cnt_d = last ? '0 : cnt_q + 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (wr_en || rd_en) begin
                    addr_d  = addr;
                    wdata_d = wdata;
                    rd_d    = ~wr_en;
                    abort_d = 1'b0;
                    phase_d = '0;
                    bit_d   = '0;
                    cnt_d   = '0;
                    rdy_d   = 1'b0;
                    state_d = START;
                end
            end
            START, GAP: adv = last;
            SEND: begin
                if (nak) begin
                    abort_d = 1'b1;
                    state_d = STOP;
                    cnt_d   = '0;
                    bit_d   = '0;
                end else if (last) begin
                    if (bit_q == 4'd8) adv = 1'b1;
                    else               bit_d = bit_q + 4'd1;
                end
            end
            RECV: begin
                if (cnt_q == C_Q3 && !bit_q[3]) begin
                    shift_d = {shift_q[6:0], sio_d_in};
                end
                if (last) begin
                    if (bit_q == 4'd8) adv = 1'b1;
                    else               bit_d = bit_q + 4'd1;
                end
            end
            STOP: adv = last;
            default: state_d = IDLE;
        endcase
        if (adv) begin
            bit_d   = '0;
            phase_d = phase_q + 4'd1;
            nxt     = abort_q ? IDLE
                              : step_state(phase_q + 4'd1, rd_q);
            state_d = nxt;
            if (nxt == IDLE) begin
                rdy_d = 1'b1;
                if (rd_q && !abort_q) begin
                    rdata_d = shift_q;
                    vld_d   = 1'b1;
                end
            end
        end
    end

    // Pin values for the coming cycle, derived from next state/count.
    always_comb begin
        sio_c_d = 1'b1;
        sda_d   = sda_q;
        oe_d    = oe_q;
        case (phase_d)
            4'd1:    tx = DEV_ID;
            4'd2:    tx = addr_q;
            4'd3:    tx = wdata_q;
            4'd6:    tx = DEV_ID | 8'h01;
            default: tx = 8'hFF;
        endcase
        txb = tx << bit_d[2:0];
        case (state_d)
            START: begin
                sda_d = (cnt_d < C_H);
                oe_d  = 1'b1;
            end
            SEND: begin
                sio_c_d = (cnt_d >= C_H);
                if (cnt_d == C_Q) begin
                    sda_d = bit_d[3] ? 1'b1 : txb[7];
                    oe_d  = ~bit_d[3];
                end
            end
            RECV: begin
                sio_c_d = (cnt_d >= C_H);
                if (cnt_d == C_Q) begin
                    sda_d = 1'b1;
                    oe_d  = bit_d[3];
                end
            end
            STOP: begin
                sio_c_d = (cnt_d >= C_Q);
                sda_d   = (cnt_d >= C_Q3);
                oe_d    = 1'b1;
            end
            default: begin
                sda_d = 1'b1;
                oe_d  = 1'b1;
            end
        endcase
    end

    // State and output registers; reset drops the bus back to idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            phase_q <= '0;
            rd_q    <= 1'b0;
            abort_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            shift_q <= '0;
            rdata_q <= '0;
            vld_q   <= 1'b0;
            rdy_q   <= 1'b1;
            sio_c_q <= 1'b1;
            sda_q   <= 1'b1;
            oe_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            phase_q <= phase_d;
            rd_q    <= rd_d;
            abort_q <= abort_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            shift_q <= shift_d;
            rdata_q <= rdata_d;
            vld_q   <= vld_d;
            rdy_q   <= rdy_d;
            sio_c_q <= sio_c_d;
            sda_q   <= sda_d;
            oe_q    <= oe_d;
        end
    end

    assign rdy       = rdy_q;
    assign rdata     = rdata_q;
    assign rdata_vld = vld_q;
    assign sio_c     = sio_c_q;
    assign sio_d_out = sda_q;
    assign sio_d_oe  = oe_q;

endmodule
